force_cache_writeback: RTL

FORCE_CACHE_WRITEBACK -- requirements
Module: force_cache_writeback

---
 rtl/force_cache_writeback.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/force_cache_writeback.sv
// Force-cache writeback: buffers accumulated-force records in a FIFO and serialises them through
// a read-add-write of a zero-initialised binary32 cache. Option macro: FORCE_CACHE_CLEAR_ON_READ_EN.
module force_cache_writeback #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned PARTICLE_ID_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0] in_particle_id,
  input  logic [DATA_WIDTH-1:0]        in_force_x,
  input  logic [DATA_WIDTH-1:0]        in_force_y,
  input  logic [DATA_WIDTH-1:0]        in_force_z,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data_x,
  output logic [DATA_WIDTH-1:0]        rd_data_y,
  output logic [DATA_WIDTH-1:0]        rd_data_z,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StInit, StIdle, StRd, StAdd, StWr} state_e;

  // binary32 add, round-to-nearest-even; subnormals are flushed to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        hi, lo;
    logic [7:0]         shamt;
    logic [26:0]        m_hi, m_lo, norm;
    logic [27:0]        acc;
    logic [24:0]        rnd;
    logic               sticky;
    logic signed [9:0]  e;
    if (a[30:0] >= b[30:0]) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    if (hi[30:23] == 8'hff) return hi;
    if (hi[30:23] == 8'h00) return {hi[31] & lo[31], 31'd0};
    if (lo[30:23] == 8'h00) return hi;
    m_hi  = {1'b1, hi[22:0], 3'b000};
    m_lo  = {1'b1, lo[22:0], 3'b000};
    shamt = hi[30:23] - lo[30:23];
    if (shamt > 8'd26) begin
      sticky = |m_lo;
      m_lo   = '0;
    end else begin
      sticky = |(m_lo & ((27'd1 << shamt) - 27'd1));
      m_lo   = m_lo >> shamt;
    end
    m_lo[0] = m_lo[0] | sticky;
    e = signed'({2'b00, hi[30:23]});
    if (hi[31] == lo[31]) acc = {1'b0, m_hi} + {1'b0, m_lo};
    else                  acc = {1'b0, m_hi} - {1'b0, m_lo};
    if (acc == 28'd0) return 32'd0;
    if (acc[27]) begin
      norm = acc[27:1] | {26'd0, acc[0]};
      e    = e + 10'sd1;
    end else begin
      norm = acc[26:0];
      for (int i = 0; i < 26; i++) begin
        if (!norm[26]) begin
          norm = norm << 1;
          e    = e - 10'sd1;
        end
      end
    end
    rnd = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'sd1;
    end
    if (e >= 10'sd255) return {hi[31], 8'hff, 23'd0};
    if (e <= 10'sd0) return {hi[31], 31'd0};
    return {hi[31], e[7:0], rnd[22:0]};
  endfunction

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic [ADDR_WIDTH-1:0] rec_addr_q;
  logic [DATA_WIDTH-1:0] rec_x_q, rec_y_q, rec_z_q;
  logic [DATA_WIDTH-1:0] op_x_q, op_y_q, op_z_q;
  logic [DATA_WIDTH-1:0] sum_x_q, sum_y_q, sum_z_q;
  logic [DATA_WIDTH-1:0] rd_hold_x_q, rd_hold_y_q, rd_hold_z_q;
  logic [PtrW:0]         wptr_q, rptr_q;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_x [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_y [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_z [FIFO_DEPTH];

  logic [DATA_WIDTH-1:0] cache_x [Depth];
  logic [DATA_WIDTH-1:0] cache_y [Depth];
  logic [DATA_WIDTH-1:0] cache_z [Depth];
  logic [DATA_WIDTH-1:0] rdat_x, rdat_y, rdat_z;

  logic                  empty, full, push, pop, rd_accept;
  logic [PtrW-1:0]       head;
  logic                  cache_we;
  logic [ADDR_WIDTH-1:0] cache_waddr, cache_raddr;
  logic [DATA_WIDTH-1:0] cache_wx, cache_wy, cache_wz;
  logic                  unused_id;

  // Only the low id bits address the cache; the rest alias.
  assign unused_id = ^in_particle_id[PARTICLE_ID_WIDTH-1:ADDR_WIDTH];

  assign head      = rptr_q[PtrW-1:0];
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop       = (state_q == StIdle) && !empty;
  assign push      = in_valid && (!full || pop);
  assign rd_accept = (state_q == StIdle) && empty && !push && rd_en;
  assign busy      = (state_q != StIdle) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr_q[PtrW-1:0]] <= in_particle_id[ADDR_WIDTH-1:0];
      fifo_x[wptr_q[PtrW-1:0]]    <= in_force_x;
      fifo_y[wptr_q[PtrW-1:0]]    <= in_force_y;
      fifo_z[wptr_q[PtrW-1:0]]    <= in_force_z;
    end
  end

  // Single write port: INIT zeroing, WR write-back and read-clear never coincide.
  always_comb begin
    cache_we    = 1'b0;
    cache_waddr = rec_addr_q;
    cache_wx    = sum_x_q;
    cache_wy    = sum_y_q;
    cache_wz    = sum_z_q;
    if (state_q == StInit) begin
      cache_we    = 1'b1;
      cache_waddr = init_cnt_q;
      cache_wx    = '0;
      cache_wy    = '0;
      cache_wz    = '0;
    end else if (state_q == StWr) begin
      cache_we = 1'b1;
`ifdef FORCE_CACHE_CLEAR_ON_READ_EN
    end else if (rd_accept) begin
      cache_we    = 1'b1;
      cache_waddr = rd_addr;
      cache_wx    = '0;
      cache_wy    = '0;
      cache_wz    = '0;
`endif
    end
  end

  assign cache_raddr = pop ? fifo_addr[head] : rd_addr;

  always_ff @(posedge clk) begin
    if (cache_we) begin
      cache_x[cache_waddr] <= cache_wx;
      cache_y[cache_waddr] <= cache_wy;
      cache_z[cache_waddr] <= cache_wz;
    end
    rdat_x <= cache_x[cache_raddr];
    rdat_y <= cache_y[cache_raddr];
    rdat_z <= cache_z[cache_raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_hold_x_q <= '0;
      rd_hold_y_q <= '0;
      rd_hold_z_q <= '0;
      rec_addr_q  <= '0;
      rec_x_q     <= '0;
      rec_y_q     <= '0;
      rec_z_q     <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      op_z_q      <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      sum_z_q     <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (in_valid && !push) overflow <= 1'b1;
      rd_valid <= rd_accept;
      if (rd_valid) begin
        rd_hold_x_q <= rdat_x;
        rd_hold_y_q <= rdat_y;
        rd_hold_z_q <= rdat_z;
      end
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (&init_cnt_q) state_q <= StIdle;
        end
        StIdle: begin
          if (pop) begin
            rec_addr_q <= fifo_addr[head];
            rec_x_q    <= fifo_x[head];
            rec_y_q    <= fifo_y[head];
            rec_z_q    <= fifo_z[head];
            state_q    <= StRd;
          end
        end
        StRd: begin
          op_x_q  <= rdat_x;
          op_y_q  <= rdat_y;
          op_z_q  <= rdat_z;
          state_q <= StAdd;
        end
        StAdd: begin
          sum_x_q <= fp_add(op_x_q, rec_x_q);
          sum_y_q <= fp_add(op_y_q, rec_y_q);
          sum_z_q <= fp_add(op_z_q, rec_z_q);
          state_q <= StWr;
        end
        StWr: state_q <= StIdle;
        default: state_q <= StInit;
      endcase
    end
  end

  // Read data follows the RAM register during the pulse and holds afterwards.
  assign rd_data_x = rd_valid ? rdat_x : rd_hold_x_q;
  assign rd_data_y = rd_valid ? rdat_y : rd_hold_y_q;
  assign rd_data_z = rd_valid ? rdat_z : rd_hold_z_q;

endmodule
